// File: rtl/alu_seq_ctrl_if.sv
// Operand/function request, ALU drive/return and display-status bundle for alu_seq_ctrl.
// The master side requests operations and supplies the ALU result; the slave is the sequencer.
interface alu_seq_ctrl_if #(
    parameter int width = 6
);
    logic                 start;
    logic [width-1:0]     a_in;
    logic [width-1:0]     b_in;
    logic [1:0]           func_in;
    logic [width-1:0]     alu_a;
    logic [width-1:0]     alu_b;
    logic [1:0]           alu_func;
    logic [2*width-1:0]   alu_result;
    logic                 alu_ovf;
    logic [2*width-1:0]   result;
    logic                 err;
    logic                 busy;
    logic                 done;
    logic                 show_operands;

    modport master (
        output start, a_in, b_in, func_in, alu_result, alu_ovf,
        input  alu_a, alu_b, alu_func, result, err, busy, done, show_operands
    );

    modport slave (
        input  start, a_in, b_in, func_in, alu_result, alu_ovf,
        output alu_a, alu_b, alu_func, result, err, busy, done, show_operands
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Latches operands on start, gives the ALU one settle cycle, registers result/overflow,
// then alternates the display between result and operand views every dwell cycles.
module alu_seq_ctrl #(
    parameter int width = 6,
    parameter int dwell = 4,
    parameter int cnt_w = 3
) (
    input  logic              clk,
    input  logic              rst,
    alu_seq_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        SHOW_RES = 2'd2,
        SHOW_OPS = 2'd3
    } state_e;

    localparam logic [cnt_w-1:0] CNT_LAST = cnt_w'(dwell - 1);

    state_e               state_q, state_d;
    logic [width-1:0]     a_q, a_d;
    logic [width-1:0]     b_q, b_d;
    logic [1:0]           func_q, func_d;
    logic [2*width-1:0]   result_q, result_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic [cnt_w-1:0]     cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            func_q   <= func_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        func_d   = func_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    func_d  = bus.func_in;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // start is deliberately ignored here: no re-latch and no queueing
                result_d = bus.alu_result;
                err_d    = bus.alu_ovf;
                done_d   = 1'b1;
                cnt_d    = '0;
                state_d  = SHOW_RES;
            end
            SHOW_RES, SHOW_OPS: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    func_d  = bus.func_in;
                    state_d = EXEC;
                end else if (err_q) begin
                    cnt_d   = '0;
                    state_d = SHOW_RES;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = (state_q == SHOW_RES) ? SHOW_OPS : SHOW_RES;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.alu_a         = a_q;
    assign bus.alu_b         = b_q;
    assign bus.alu_func      = func_q;
    assign bus.result        = result_q;
    assign bus.err           = err_q;
    assign bus.done          = done_q;
    assign bus.busy          = (state_q == EXEC);
    assign bus.show_operands = (state_q == IDLE) || (state_q == SHOW_OPS);
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed and randomized bench for alu_seq_ctrl against a timeline-based reference model.
module tb_alu_seq_ctrl;
    localparam int W = 6;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ovf_mode = 1'b0;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.width(W)) bus ();

    alu_seq_ctrl #(.width(W), .dwell(DW), .cnt_w(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [2*W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] f);
        case (f)
            2'd0:    return (2*W)'(a) + (2*W)'(b);
            2'd1:    return (2*W)'(a) - (2*W)'(b);
            2'd2:    return (2*W)'(a) * (2*W)'(b);
            default: return {a, b};
        endcase
    endfunction

    assign bus.alu_result = ovf_mode ? '1 : alu_fn(bus.alu_a, bus.alu_b, bus.alu_func);
    assign bus.alu_ovf    = ovf_mode;

    // Reference model: what matters is whether an op is pending, and how many
    // cycles have elapsed since the last capture; the view follows from that count.
    logic [W-1:0]   m_a = '0, m_b = '0;
    logic [1:0]     m_f = '0;
    logic [2*W-1:0] m_result = '0;
    logic           m_err = 1'b0, m_done = 1'b0, m_exec = 1'b0, m_idle = 1'b1;
    int             m_since = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_a = '0; m_b = '0; m_f = '0; m_result = '0;
            m_err = 1'b0; m_done = 1'b0; m_exec = 1'b0; m_idle = 1'b1; m_since = 0;
        end else begin
            m_done = 1'b0;
            if (m_exec) begin
                m_result = ovf_mode ? '1 : alu_fn(m_a, m_b, m_f);
                m_err    = ovf_mode;
                m_done   = 1'b1;
                m_since  = 0;
                m_exec   = 1'b0;
                m_idle   = 1'b0;
            end else if (bus.start) begin
                m_a = bus.a_in; m_b = bus.b_in; m_f = bus.func_in;
                m_exec = 1'b1;
            end else if (!m_idle) begin
                m_since++;
            end
        end
    end

    function automatic logic exp_show();
        if (m_exec)     return 1'b0;
        if (m_idle)     return 1'b1;
        if (m_err)      return 1'b0;
        return ((m_since / DW) % 2) == 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m.alu_a",    32'(bus.alu_a),         32'(m_a));
            chk("m.alu_b",    32'(bus.alu_b),         32'(m_b));
            chk("m.alu_func", 32'(bus.alu_func),      32'(m_f));
            chk("m.result",   32'(bus.result),        32'(m_result));
            chk("m.err",      32'(bus.err),           32'(m_err));
            chk("m.done",     32'(bus.done),          32'(m_done));
            chk("m.busy",     32'(bus.busy),          32'(m_exec));
            chk("m.show",     32'(bus.show_operands), 32'(exp_show()));
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f);
        bus.a_in = a; bus.b_in = b; bus.func_in = f; bus.start = 1'b1;
    endtask

    initial begin
        bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.func_in = '0;

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst.result", 32'(bus.result), 32'h0);
        chk("rst.err",    32'(bus.err), 32'h0);
        chk("rst.done",   32'(bus.done), 32'h0);
        chk("rst.busy",   32'(bus.busy), 32'h0);
        chk("rst.show",   32'(bus.show_operands), 32'h1);
        chk("rst.alu_a",  32'(bus.alu_a), 32'h0);
        rst = 1'b0;

        // Single op: 5 + 3
        @(negedge clk); issue(6'd5, 6'd3, 2'd0);
        @(negedge clk); bus.start = 1'b0;
        chk("op.alu_a", 32'(bus.alu_a), 32'd5);
        chk("op.alu_b", 32'(bus.alu_b), 32'd3);
        chk("op.busy",  32'(bus.busy), 32'h1);
        @(negedge clk);
        chk("op.result", 32'(bus.result), 32'h008);
        chk("op.done",   32'(bus.done), 32'h1);
        chk("op.busy0",  32'(bus.busy), 32'h0);

        // Alternation 0x4, 1x4, 0x4 with no further done pulse
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                @(negedge clk);
                chk("alt.done", 32'(bus.done), 32'h0);
            end
            chk("alt.show", 32'(bus.show_operands), 32'((i / 4) % 2));
        end

        // Overflow holds the result view
        @(negedge clk); ovf_mode = 1'b1; issue(6'd9, 6'd7, 2'd2);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); ovf_mode = 1'b0;
        chk("ovf.err",    32'(bus.err), 32'h1);
        chk("ovf.result", 32'(bus.result), 32'hFFF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("ovf.hold", 32'(bus.show_operands), 32'h0);
        end
        issue(6'd5, 6'd3, 2'd0);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        chk("ovf.clear", 32'(bus.err), 32'h0);
        repeat (4) @(negedge clk);
        chk("ovf.resume", 32'(bus.show_operands), 32'h1);

        // start during EXEC ignored; start at last SHOW_OPS cycle accepted
        @(negedge clk); issue(6'd5, 6'd3, 2'd0);
        @(negedge clk); issue(6'd7, 6'd1, 2'd1);
        @(negedge clk); bus.start = 1'b0;
        chk("ign.alu_a", 32'(bus.alu_a), 32'd5);
        repeat (7) @(negedge clk);
        chk("late.show", 32'(bus.show_operands), 32'h1);
        issue(6'd3, 6'd4, 2'd2);
        @(negedge clk); bus.start = 1'b0;
        chk("late.busy",  32'(bus.busy), 32'h1);
        chk("late.alu_a", 32'(bus.alu_a), 32'd3);
        @(negedge clk);
        chk("late.result", 32'(bus.result), 32'h00C);

        // Reset during EXEC
        @(negedge clk); issue(6'd1, 6'd2, 2'd3);
        @(negedge clk); bus.start = 1'b0;
        chk("rx.busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rx.busy0",  32'(bus.busy), 32'h0);
        chk("rx.show",   32'(bus.show_operands), 32'h1);
        chk("rx.result", 32'(bus.result), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rx.done", 32'(bus.done), 32'h0);
        end

        // Randomized traffic; every cycle is checked by the model comparator
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.start   = ($urandom_range(0, 9) < 3);
            bus.a_in    = W'($urandom);
            bus.b_in    = W'($urandom);
            bus.func_in = 2'($urandom);
            ovf_mode    = ($urandom_range(0, 9) < 2);
            rst         = ($urandom_range(0, 99) < 2);
        end
        @(negedge clk); bus.start = 1'b0; rst = 1'b0; ovf_mode = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
